id_pipe: RTL and testbench
==========================

Name: id_pipe

Overview:
- Parametrised, registered successor of the combinational decode stage. Sits between if_id and id_ex.
- Decodes the full RV32I base integer set (except FENCE/SYSTEM) into operands and control.
- Holds the result in an output register with valid/ready handshakes on both sides.
- Detects load-use hazards against the instruction it holds and inserts a bubble; supports flush from EX on taken branch/jump.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64; all immediates and operands are sign-extended to XLEN.
- REG_AW, 5, register address width.
- LOAD_USE_EN, 1, 1 = load-use interlock active; 0 = interlock disabled (hazard forced 0).
- NOP_INST, 32'h0000_0013, value driven on inst_o while empty or in reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  if_id holds an instruction
- in_ready  out  1  id_pipe accepts the instruction this cycle
- inst_i  in  32  instruction
- inst_addr_i  in  XLEN  instruction address
- rs1_addr_o  out  REG_AW  regfile read address 1 (combinational from inst_i)
- rs2_addr_o  out  REG_AW  regfile read address 2 (combinational from inst_i)
- rs1_data_i  in  XLEN  regfile read data 1
- rs2_data_i  in  XLEN  regfile read data 2
- flush_i  in  1  EX redirect; kill held and incoming instruction
- out_valid  out  1  output register holds a valid instruction
- out_ready  in  1  id_ex accepts
- inst_o  out  32  registered instruction
- inst_addr_o  out  XLEN  registered address
- op1_o  out  XLEN  operand 1
- op2_o  out  XLEN  operand 2
- imm_o  out  XLEN  format immediate
- store_data_o  out  XLEN  store data (rs2 value)
- rd_addr_o  out  REG_AW  destination register
- reg_wen  out  1  register write enable
- mem_ren_o  out  1  load
- mem_wen_o  out  1  store
- illegal_o  out  1  unsupported encoding

Behaviour:
- Reset (rst=1 at clk edge): out_valid=0, inst_o=NOP_INST, all other registered outputs 0.
- Read addresses are combinational from inst_i. Unused rs1/rs2 address is driven 0.
- advance = !out_valid | out_ready.
- Hazard (LOAD_USE_EN=1): hazard = out_valid & mem_ren_o & rd_addr_o!=0 & ((uses_rs1 & rs1==rd_addr_o) | (uses_rs2 & rs2==rd_addr_o)).
- Handshake: in_ready = advance & !hazard. in_ready has no dependence on in_valid.
- Update priority at each clk edge when advance=1:
  - flush_i=1: out_valid←0. An incoming accepted instruction is discarded.
  - else if in_valid & !hazard: load the decoded instruction, out_valid←1.
  - else: out_valid←0 (bubble).
- advance=0: all registers hold. flush_i is ignored; EX asserts flush only while accepting.
- Latency: 1 cycle from acceptance to out_valid. Throughput: 1 instruction per cycle without hazard. A load-use pair costs exactly 1 bubble.
- Decode (registered values):
  - OP-IMM, all funct3: op1=rs1, op2=imm_i. SLLI/SRLI/SRAI require funct7 0/0/0x20 (bit25=0 for XLEN=32), else illegal.
  - OP: op1=rs1, op2=rs2. funct7 must be 0, or 0x20 for SUB/SRA, else illegal.
  - BRANCH (funct3 ∉ {2,3}): op1=rs1, op2=rs2, imm=imm_b, reg_wen=0.
  - JAL: op1=inst_addr, op2=imm_j. JALR (funct3=0): op1=rs1, op2=imm_i. Both reg_wen=1; link computed in EX.
  - LUI: op1=imm_u, op2=0. AUIPC: op1=inst_addr, op2=imm_u.
  - LOAD (funct3 ∈ {0,1,2,4,5}): op1=rs1, op2=imm_i, mem_ren=1.
  - STORE (funct3 ∈ {0,1,2}): op1=rs1, op2=imm_s, store_data=rs2, mem_wen=1, reg_wen=0.
  - imm_o always carries the format immediate: I/S/B/U/J, sign-extended from bit 31.
  - reg_wen is forced 0 when rd=0.
  - Illegal/unsupported encoding: illegal_o=1, and reg_wen, mem_ren, mem_wen, op1, op2 are all 0. It still flows with out_valid=1 so a trap can be raised downstream.
- Registered outputs never change while out_valid & !out_ready.

Decomposition:
- Shared package/defines.v: opcode and funct3/funct7 constants (extend the existing INST_* set with OP-IMM, LOAD, STORE, JALR, AUIPC codes), NOP encoding.
- One combinational sub-module, id_decode: inst_i, addr, read data → operand/control bundle plus uses_rs1/uses_rs2.
- id_pipe contains only the handshake, hazard logic and output register.

Test Plan:
- addi x1,x0,-5 (0xFFB00093) at addr 0x100, out_ready=1 → next cycle out_valid=1, op2_o=0xFFFFFFFB, rd=1, reg_wen=1.
- lw x5,0(x2) then add x6,x5,x1 back-to-back → in_ready=0 for 1 cycle, one bubble (out_valid=0), then add emitted with rs1_addr=5.
- Same pair with LOAD_USE_EN=0, or dependency via x0 → no stall.
- out_ready=0 for 3 cycles with lui x3,0x12345 held → outputs stable at op1_o=0x12345000, in_ready=0; release → accept next.
- flush_i=1 together with in_valid=1 → out_valid=0 next cycle; the following instruction issues normally.
- 0xFFFFFFFF, and add with funct7=0x01 → illegal_o=1, reg_wen=0, out_valid=1. JAL imm=-4 → op2_o=0xFFFFFFFC, op1_o=inst_addr.

Source files
------------

// File: rtl/id_pipe_pkg.sv
// Shared RV32I decode constants, operand-select encodings and the control bundle
// passed from id_decode to id_pipe.
package id_pipe_pkg;

  localparam int unsigned INST_W = 32;

  localparam logic [6:0] INST_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] INST_OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] INST_OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] INST_OP_STORE  = 7'b0100011;
  localparam logic [6:0] INST_OP_OP     = 7'b0110011;
  localparam logic [6:0] INST_OP_LUI    = 7'b0110111;
  localparam logic [6:0] INST_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] INST_OP_JALR   = 7'b1100111;
  localparam logic [6:0] INST_OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_SR      = 3'b101;
  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [2:0] F3_LB      = 3'b000;
  localparam logic [2:0] F3_LH      = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_LBU     = 3'b100;
  localparam logic [2:0] F3_LHU     = 3'b101;
  localparam logic [2:0] F3_SB      = 3'b000;
  localparam logic [2:0] F3_SH      = 3'b001;
  localparam logic [2:0] F3_SW      = 3'b010;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;
  // Shift-immediate funct6: bit 25 belongs to shamt on 64-bit datapaths.
  localparam logic [5:0] F6_BASE = 6'h00;
  localparam logic [5:0] F6_ALT  = 6'h10;

  localparam logic [INST_W-1:0] INST_NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

  typedef enum logic [1:0] {
    OP1_ZERO,
    OP1_RS1,
    OP1_PC,
    OP1_IMM
  } op1_sel_e;

  typedef enum logic [1:0] {
    OP2_ZERO,
    OP2_RS2,
    OP2_IMM
  } op2_sel_e;

  typedef struct packed {
    logic reg_wen;
    logic mem_ren;
    logic mem_wen;
    logic illegal;
    logic uses_rs1;
    logic uses_rs2;
  } dec_ctrl_t;

  // 32-bit sign-extended immediate for the given format.
  function automatic logic [31:0] imm_of(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{inst[31]}}, inst[31:20]};
      FMT_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      FMT_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      FMT_U:   imm = {inst[31:12], 12'h000};
      FMT_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/id_decode.sv
// Combinational RV32I decoder: instruction, address and register read data in,
// operand/control bundle and source-usage flags out.
module id_decode
  import id_pipe_pkg::*;
#(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned REG_AW = 5
) (
  input  logic [INST_W-1:0] i_inst,
  input  logic [XLEN-1:0]   i_inst_addr,
  input  logic [XLEN-1:0]   i_rs1_data,
  input  logic [XLEN-1:0]   i_rs2_data,
  output logic [REG_AW-1:0] o_rs1_addr_c,
  output logic [REG_AW-1:0] o_rs2_addr_c,
  output logic [REG_AW-1:0] o_rd_addr_c,
  output logic [XLEN-1:0]   o_op1_c,
  output logic [XLEN-1:0]   o_op2_c,
  output logic [XLEN-1:0]   o_imm_c,
  output logic [XLEN-1:0]   o_store_data_c,
  output dec_ctrl_t         o_ctrl_c
);

  logic [6:0]      w_opc;
  logic [2:0]      w_f3;
  logic [6:0]      w_f7;
  logic [5:0]      w_f6;
  logic            w_shamt_ok;
  imm_fmt_e        w_fmt;
  logic [XLEN-1:0] w_imm;
  logic            w_legal;
  logic            w_writes;
  logic            w_use1;
  logic            w_use2;
  logic            w_load;
  logic            w_store;
  op1_sel_e        w_op1_sel;
  op2_sel_e        w_op2_sel;

  assign w_opc      = i_inst[6:0];
  assign w_f3       = i_inst[14:12];
  assign w_f7       = i_inst[31:25];
  assign w_f6       = i_inst[31:26];
  assign w_shamt_ok = (XLEN == 64) || !i_inst[25];

  // Immediate format depends on opcode only, so it is reported even for bad funct fields.
  always_comb begin
    w_fmt = FMT_NONE;
    case (w_opc)
      INST_OP_OP_IMM, INST_OP_JALR, INST_OP_LOAD: w_fmt = FMT_I;
      INST_OP_STORE:                              w_fmt = FMT_S;
      INST_OP_BRANCH:                             w_fmt = FMT_B;
      INST_OP_LUI, INST_OP_AUIPC:                 w_fmt = FMT_U;
      INST_OP_JAL:                                w_fmt = FMT_J;
      default:                                    w_fmt = FMT_NONE;
    endcase
  end

  assign w_imm = XLEN'($signed(imm_of(i_inst, w_fmt)));

  // Legality and selects never look at read data, keeping the regfile path loop-free.
  always_comb begin
    w_legal   = 1'b0;
    w_writes  = 1'b0;
    w_use1    = 1'b0;
    w_use2    = 1'b0;
    w_load    = 1'b0;
    w_store   = 1'b0;
    w_op1_sel = OP1_ZERO;
    w_op2_sel = OP2_ZERO;
    case (w_opc)
      INST_OP_OP_IMM: begin
        w_use1    = 1'b1;
        w_writes  = 1'b1;
        w_op1_sel = OP1_RS1;
        w_op2_sel = OP2_IMM;
        case (w_f3)
          F3_SLL:  w_legal = w_shamt_ok && (w_f6 == F6_BASE);
          F3_SR:   w_legal = w_shamt_ok && ((w_f6 == F6_BASE) || (w_f6 == F6_ALT));
          default: w_legal = 1'b1;
        endcase
      end
      INST_OP_OP: begin
        w_use1    = 1'b1;
        w_use2    = 1'b1;
        w_writes  = 1'b1;
        w_op1_sel = OP1_RS1;
        w_op2_sel = OP2_RS2;
        w_legal   = (w_f7 == F7_BASE) ||
                    ((w_f7 == F7_ALT) && ((w_f3 == F3_ADD_SUB) || (w_f3 == F3_SR)));
      end
      INST_OP_BRANCH: begin
        w_use1    = 1'b1;
        w_use2    = 1'b1;
        w_op1_sel = OP1_RS1;
        w_op2_sel = OP2_RS2;
        w_legal   = (w_f3 != F3_SLT) && (w_f3 != F3_SLTU);
      end
      INST_OP_JAL: begin
        w_writes  = 1'b1;
        w_op1_sel = OP1_PC;
        w_op2_sel = OP2_IMM;
        w_legal   = 1'b1;
      end
      INST_OP_JALR: begin
        w_use1    = 1'b1;
        w_writes  = 1'b1;
        w_op1_sel = OP1_RS1;
        w_op2_sel = OP2_IMM;
        w_legal   = (w_f3 == F3_JALR);
      end
      INST_OP_LUI: begin
        w_writes  = 1'b1;
        w_op1_sel = OP1_IMM;
        w_legal   = 1'b1;
      end
      INST_OP_AUIPC: begin
        w_writes  = 1'b1;
        w_op1_sel = OP1_PC;
        w_op2_sel = OP2_IMM;
        w_legal   = 1'b1;
      end
      INST_OP_LOAD: begin
        w_use1    = 1'b1;
        w_writes  = 1'b1;
        w_load    = 1'b1;
        w_op1_sel = OP1_RS1;
        w_op2_sel = OP2_IMM;
        w_legal   = (w_f3 == F3_LB) || (w_f3 == F3_LH) || (w_f3 == F3_LW) ||
                    (w_f3 == F3_LBU) || (w_f3 == F3_LHU);
      end
      INST_OP_STORE: begin
        w_use1    = 1'b1;
        w_use2    = 1'b1;
        w_store   = 1'b1;
        w_op1_sel = OP1_RS1;
        w_op2_sel = OP2_IMM;
        w_legal   = (w_f3 == F3_SB) || (w_f3 == F3_SH) || (w_f3 == F3_SW);
      end
      default: w_legal = 1'b0;
    endcase
  end

  assign o_rs1_addr_c = (w_legal && w_use1) ? REG_AW'(i_inst[19:15]) : '0;
  assign o_rs2_addr_c = (w_legal && w_use2) ? REG_AW'(i_inst[24:20]) : '0;
  assign o_rd_addr_c  = REG_AW'(i_inst[11:7]);
  assign o_imm_c      = w_imm;

  // Operand muxes; an illegal encoding zeroes every operand.
  always_comb begin
    o_op1_c        = '0;
    o_op2_c        = '0;
    o_store_data_c = '0;
    if (w_legal) begin
      case (w_op1_sel)
        OP1_RS1: o_op1_c = i_rs1_data;
        OP1_PC:  o_op1_c = i_inst_addr;
        OP1_IMM: o_op1_c = w_imm;
        default: o_op1_c = '0;
      endcase
      case (w_op2_sel)
        OP2_RS2: o_op2_c = i_rs2_data;
        OP2_IMM: o_op2_c = w_imm;
        default: o_op2_c = '0;
      endcase
      if (w_store) o_store_data_c = i_rs2_data;
    end
  end

  always_comb begin
    o_ctrl_c          = '0;
    o_ctrl_c.reg_wen  = w_legal && w_writes && (i_inst[11:7] != 5'd0);
    o_ctrl_c.mem_ren  = w_legal && w_load;
    o_ctrl_c.mem_wen  = w_legal && w_store;
    o_ctrl_c.illegal  = !w_legal;
    o_ctrl_c.uses_rs1 = w_legal && w_use1;
    o_ctrl_c.uses_rs2 = w_legal && w_use2;
  end

endmodule

// File: rtl/id_pipe.sv
// Registered decode stage between if_id and id_ex: valid/ready on both sides,
// load-use interlock against the held instruction, and EX-driven flush.
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int unsigned       XLEN        = 32,
  parameter int unsigned       REG_AW      = 5,
  parameter bit                LOAD_USE_EN = 1'b1,
  parameter logic [INST_W-1:0] NOP_INST    = INST_NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [INST_W-1:0] inst_i,
  input  logic [XLEN-1:0]   inst_addr_i,
  output logic [REG_AW-1:0] rs1_addr_o,
  output logic [REG_AW-1:0] rs2_addr_o,
  input  logic [XLEN-1:0]   rs1_data_i,
  input  logic [XLEN-1:0]   rs2_data_i,
  input  logic              flush_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [INST_W-1:0] inst_o,
  output logic [XLEN-1:0]   inst_addr_o,
  output logic [XLEN-1:0]   op1_o,
  output logic [XLEN-1:0]   op2_o,
  output logic [XLEN-1:0]   imm_o,
  output logic [XLEN-1:0]   store_data_o,
  output logic [REG_AW-1:0] rd_addr_o,
  output logic              reg_wen,
  output logic              mem_ren_o,
  output logic              mem_wen_o,
  output logic              illegal_o
);

  logic [REG_AW-1:0] w_rs1_addr;
  logic [REG_AW-1:0] w_rs2_addr;
  logic [REG_AW-1:0] w_rd_addr;
  logic [XLEN-1:0]   w_op1;
  logic [XLEN-1:0]   w_op2;
  logic [XLEN-1:0]   w_imm;
  logic [XLEN-1:0]   w_store_data;
  dec_ctrl_t         w_ctrl;
  logic              w_advance;
  logic              w_hazard;
  logic              w_load;

  logic              r_out_valid;
  logic [INST_W-1:0] r_inst;
  logic [XLEN-1:0]   r_inst_addr;
  logic [XLEN-1:0]   r_op1;
  logic [XLEN-1:0]   r_op2;
  logic [XLEN-1:0]   r_imm;
  logic [XLEN-1:0]   r_store_data;
  logic [REG_AW-1:0] r_rd_addr;
  logic              r_reg_wen;
  logic              r_mem_ren;
  logic              r_mem_wen;
  logic              r_illegal;

  id_decode #(
    .XLEN   (XLEN),
    .REG_AW (REG_AW)
  ) u_decode (
    .i_inst         (inst_i),
    .i_inst_addr    (inst_addr_i),
    .i_rs1_data     (rs1_data_i),
    .i_rs2_data     (rs2_data_i),
    .o_rs1_addr_c   (w_rs1_addr),
    .o_rs2_addr_c   (w_rs2_addr),
    .o_rd_addr_c    (w_rd_addr),
    .o_op1_c        (w_op1),
    .o_op2_c        (w_op2),
    .o_imm_c        (w_imm),
    .o_store_data_c (w_store_data),
    .o_ctrl_c       (w_ctrl)
  );

  assign rs1_addr_o = w_rs1_addr;
  assign rs2_addr_o = w_rs2_addr;

  assign w_advance = !r_out_valid || out_ready;

  // A held load whose destination feeds the incoming instruction forces one bubble.
  assign w_hazard = LOAD_USE_EN && r_out_valid && r_mem_ren && (r_rd_addr != '0) &&
                    ((w_ctrl.uses_rs1 && (w_rs1_addr == r_rd_addr)) ||
                     (w_ctrl.uses_rs2 && (w_rs2_addr == r_rd_addr)));

  assign in_ready = w_advance && !w_hazard;
  assign w_load   = !flush_i && in_valid && !w_hazard;

  // Output register: flush and hazard both become a bubble with NOP contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_inst       <= NOP_INST;
      r_inst_addr  <= '0;
      r_op1        <= '0;
      r_op2        <= '0;
      r_imm        <= '0;
      r_store_data <= '0;
      r_rd_addr    <= '0;
      r_reg_wen    <= 1'b0;
      r_mem_ren    <= 1'b0;
      r_mem_wen    <= 1'b0;
      r_illegal    <= 1'b0;
    end else if (w_advance) begin
      r_out_valid <= w_load;
      if (w_load) begin
        r_inst       <= inst_i;
        r_inst_addr  <= inst_addr_i;
        r_op1        <= w_op1;
        r_op2        <= w_op2;
        r_imm        <= w_imm;
        r_store_data <= w_store_data;
        r_rd_addr    <= w_rd_addr;
        r_reg_wen    <= w_ctrl.reg_wen;
        r_mem_ren    <= w_ctrl.mem_ren;
        r_mem_wen    <= w_ctrl.mem_wen;
        r_illegal    <= w_ctrl.illegal;
      end else begin
        r_inst       <= NOP_INST;
        r_inst_addr  <= '0;
        r_op1        <= '0;
        r_op2        <= '0;
        r_imm        <= '0;
        r_store_data <= '0;
        r_rd_addr    <= '0;
        r_reg_wen    <= 1'b0;
        r_mem_ren    <= 1'b0;
        r_mem_wen    <= 1'b0;
        r_illegal    <= 1'b0;
      end
    end
  end

  assign out_valid    = r_out_valid;
  assign inst_o       = r_inst;
  assign inst_addr_o  = r_inst_addr;
  assign op1_o        = r_op1;
  assign op2_o        = r_op2;
  assign imm_o        = r_imm;
  assign store_data_o = r_store_data;
  assign rd_addr_o    = r_rd_addr;
  assign reg_wen      = r_reg_wen;
  assign mem_ren_o    = r_mem_ren;
  assign mem_wen_o    = r_mem_wen;
  assign illegal_o    = r_illegal;

endmodule

// File: tb/tb_id_pipe.sv
// Bench for id_pipe: directed scenarios plus random traffic checked against a
// cycle-level reference model built from the RV32I decode rules.
module tb_id_pipe;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] addr;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [31:0] sd;
    logic [4:0]  rd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic        wen;
    logic        ren;
    logic        men;
    logic        ill;
    logic        u1;
    logic        u2;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        flush_i;
  logic        out_ready;

  logic        in_ready, out_valid, reg_wen, mem_ren_o, mem_wen_o, illegal_o;
  logic [4:0]  rs1_addr_o, rs2_addr_o, rd_addr_o;
  logic [31:0] rs1_data_i, rs2_data_i, inst_o, inst_addr_o, op1_o, op2_o, imm_o, store_data_o;

  logic        n_in_ready, n_out_valid, n_reg_wen, n_mem_ren, n_mem_wen, n_illegal;
  logic [4:0]  n_rs1_addr, n_rs2_addr, n_rd_addr;
  logic [31:0] n_rs1_data, n_rs2_data, n_inst, n_inst_addr, n_op1, n_op2, n_imm, n_store_data;

  logic [31:0] regs [32];
  int          total;
  int          bad;
  bit          m_valid;
  exp_t        m_e;
  logic        last_rdy;
  logic        last_n_rdy;
  logic [4:0]  last_rs1;

  always #5 clk = ~clk;

  assign rs1_data_i = regs[rs1_addr_o];
  assign rs2_data_i = regs[rs2_addr_o];
  assign n_rs1_data = regs[n_rs1_addr];
  assign n_rs2_data = regs[n_rs2_addr];

  id_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .rs1_addr_o(rs1_addr_o), .rs2_addr_o(rs2_addr_o),
    .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .flush_i(flush_i),
    .out_valid(out_valid), .out_ready(out_ready), .inst_o(inst_o), .inst_addr_o(inst_addr_o),
    .op1_o(op1_o), .op2_o(op2_o), .imm_o(imm_o), .store_data_o(store_data_o),
    .rd_addr_o(rd_addr_o), .reg_wen(reg_wen), .mem_ren_o(mem_ren_o),
    .mem_wen_o(mem_wen_o), .illegal_o(illegal_o)
  );

  id_pipe #(.LOAD_USE_EN(1'b0)) dut_noil (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(n_in_ready),
    .inst_i(inst_i), .inst_addr_i(inst_addr_i),
    .rs1_addr_o(n_rs1_addr), .rs2_addr_o(n_rs2_addr),
    .rs1_data_i(n_rs1_data), .rs2_data_i(n_rs2_data), .flush_i(flush_i),
    .out_valid(n_out_valid), .out_ready(out_ready), .inst_o(n_inst), .inst_addr_o(n_inst_addr),
    .op1_o(n_op1), .op2_o(n_op2), .imm_o(n_imm), .store_data_o(n_store_data),
    .rd_addr_o(n_rd_addr), .reg_wen(n_reg_wen), .mem_ren_o(n_mem_ren),
    .mem_wen_o(n_mem_wen), .illegal_o(n_illegal)
  );

  function automatic exp_t bubble();
    exp_t b;
    b      = '0;
    b.inst = NOP;
    return b;
  endfunction

  // What the instruction means, straight from the ISA tables.
  function automatic exp_t model_dec(input logic [31:0] ins, input logic [31:0] pc);
    exp_t        e;
    logic [31:0] ii, is, ib, iu, ij, a, b;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic        ok, wr;
    e = '0;
    e.inst = ins;
    e.addr = pc;
    e.rd   = ins[11:7];
    f3 = ins[14:12];
    f7 = ins[31:25];
    a  = regs[ins[19:15]];
    b  = regs[ins[24:20]];
    ii = 32'($signed(ins[31:20]));
    is = 32'($signed({ins[31:25], ins[11:7]}));
    ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
    iu = {ins[31:12], 12'h000};
    ij = 32'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
    ok = 1'b0;
    wr = 1'b0;
    case (ins[6:0])
      7'h13: begin
        e.imm = ii; e.u1 = 1; e.op1 = a; e.op2 = ii; wr = 1;
        if (f3 == 3'd1)      ok = (f7 == 7'h00);
        else if (f3 == 3'd5) ok = (f7 == 7'h00) || (f7 == 7'h20);
        else                 ok = 1;
      end
      7'h33: begin
        e.u1 = 1; e.u2 = 1; e.op1 = a; e.op2 = b; wr = 1;
        ok = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      7'h63: begin e.imm = ib; e.u1 = 1; e.u2 = 1; e.op1 = a; e.op2 = b; ok = (f3 != 3'd2) && (f3 != 3'd3); end
      7'h6F: begin e.imm = ij; e.op1 = pc; e.op2 = ij; wr = 1; ok = 1; end
      7'h67: begin e.imm = ii; e.u1 = 1; e.op1 = a; e.op2 = ii; wr = 1; ok = (f3 == 3'd0); end
      7'h37: begin e.imm = iu; e.op1 = iu; wr = 1; ok = 1; end
      7'h17: begin e.imm = iu; e.op1 = pc; e.op2 = iu; wr = 1; ok = 1; end
      7'h03: begin
        e.imm = ii; e.u1 = 1; e.op1 = a; e.op2 = ii; wr = 1; e.ren = 1;
        ok = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
      end
      7'h23: begin e.imm = is; e.u1 = 1; e.u2 = 1; e.op1 = a; e.op2 = is; e.sd = b; e.men = 1; ok = (f3 <= 3'd2); end
      default: ok = 0;
    endcase
    if (!ok) begin
      e.op1 = '0; e.op2 = '0; e.sd = '0; e.ren = 0; e.men = 0; e.u1 = 0; e.u2 = 0; wr = 0; e.ill = 1;
    end
    e.r1  = e.u1 ? ins[19:15] : 5'd0;
    e.r2  = e.u2 ? ins[24:20] : 5'd0;
    e.wen = wr && (e.rd != 5'd0);
    return e;
  endfunction

  function automatic logic [31:0] rnd_inst();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 11))
      0: r[6:0] = 7'h13;  1: r[6:0] = 7'h33;  2: r[6:0] = 7'h63;  3: r[6:0] = 7'h6F;
      4: r[6:0] = 7'h67;  5: r[6:0] = 7'h37;  6: r[6:0] = 7'h17;  7: r[6:0] = 7'h03;
      8: r[6:0] = 7'h23;  9: r[6:0] = 7'h0F; 10: r[6:0] = 7'h73;
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) r[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    if ($urandom_range(0, 2) != 0) begin
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      r[11:7]  = 5'($urandom_range(0, 3));
    end
    return r;
  endfunction

  // One clock: drive at negedge, check combinational outputs, step model, check registers.
  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic fl, input logic ordy);
    exp_t d;
    logic hz, adv, exp_rdy;
    in_valid = v; inst_i = ins; inst_addr_i = pc; flush_i = fl; out_ready = ordy;
    #1;
    d       = model_dec(ins, pc);
    adv     = !m_valid || ordy;
    hz      = m_valid && m_e.ren && (m_e.rd != 5'd0) &&
              ((d.u1 && d.r1 == m_e.rd) || (d.u2 && d.r2 == m_e.rd));
    exp_rdy = adv && !hz;
    last_rdy   = in_ready;
    last_n_rdy = n_in_ready;
    last_rs1   = rs1_addr_o;
    total++; if (in_ready !== exp_rdy) begin bad++; $display("FAIL in_ready got=%b exp=%b inst=%h t=%0t", in_ready, exp_rdy, ins, $time); end
    total++; if ({rs1_addr_o, rs2_addr_o} !== {d.r1, d.r2}) begin bad++; $display("FAIL rs_addr got=%h/%h exp=%h/%h inst=%h", rs1_addr_o, rs2_addr_o, d.r1, d.r2, ins); end
    @(posedge clk);
    if (adv) begin
      if (!fl && v && !hz) begin m_valid = 1; m_e = d; end
      else begin m_valid = 0; m_e = bubble(); end
    end
    @(negedge clk);
    total++; if (out_valid !== m_valid) begin bad++; $display("FAIL out_valid got=%b exp=%b t=%0t", out_valid, m_valid, $time); end
    total++; if (inst_o !== m_e.inst) begin bad++; $display("FAIL inst_o got=%h exp=%h", inst_o, m_e.inst); end
    total++; if (inst_addr_o !== m_e.addr) begin bad++; $display("FAIL inst_addr got=%h exp=%h", inst_addr_o, m_e.addr); end
    total++; if (op1_o !== m_e.op1) begin bad++; $display("FAIL op1 got=%h exp=%h inst=%h", op1_o, m_e.op1, m_e.inst); end
    total++; if (op2_o !== m_e.op2) begin bad++; $display("FAIL op2 got=%h exp=%h inst=%h", op2_o, m_e.op2, m_e.inst); end
    total++; if (imm_o !== m_e.imm) begin bad++; $display("FAIL imm got=%h exp=%h inst=%h", imm_o, m_e.imm, m_e.inst); end
    total++; if (store_data_o !== m_e.sd) begin bad++; $display("FAIL store_data got=%h exp=%h inst=%h", store_data_o, m_e.sd, m_e.inst); end
    total++; if (rd_addr_o !== m_e.rd) begin bad++; $display("FAIL rd_addr got=%h exp=%h", rd_addr_o, m_e.rd); end
    total++; if ({reg_wen, mem_ren_o, mem_wen_o, illegal_o} !== {m_e.wen, m_e.ren, m_e.men, m_e.ill}) begin
      bad++; $display("FAIL ctrl wen/ren/men/ill got=%b exp=%b inst=%h", {reg_wen, mem_ren_o, mem_wen_o, illegal_o}, {m_e.wen, m_e.ren, m_e.men, m_e.ill}, m_e.inst);
    end
  endtask

  task automatic test_reset();
    rst = 1; in_valid = 1; inst_i = 32'hFFB00093; inst_addr_i = 32'h10; flush_i = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset out_valid got=%b exp=0", out_valid); end
    total++; if (inst_o !== NOP) begin bad++; $display("FAIL reset inst_o got=%h exp=%h", inst_o, NOP); end
    total++; if ({inst_addr_o, op1_o, op2_o, imm_o, store_data_o} !== 160'd0) begin bad++; $display("FAIL reset data got=%h exp=0", {inst_addr_o, op1_o, op2_o, imm_o, store_data_o}); end
    total++; if ({rd_addr_o, reg_wen, mem_ren_o, mem_wen_o, illegal_o} !== 9'd0) begin bad++; $display("FAIL reset ctrl got=%h exp=0", {rd_addr_o, reg_wen, mem_ren_o, mem_wen_o, illegal_o}); end
    rst = 0;
    m_valid = 0;
    m_e = bubble();
  endtask

  task automatic test_addi();
    cycle(1, 32'hFFB00093, 32'h100, 0, 1);
    total++; if ({out_valid, op2_o, rd_addr_o, reg_wen} !== {1'b1, 32'hFFFFFFFB, 5'd1, 1'b1}) begin
      bad++; $display("FAIL addi got v=%b op2=%h rd=%0d wen=%b exp v=1 op2=fffffffb rd=1 wen=1", out_valid, op2_o, rd_addr_o, reg_wen);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      cycle(1, {12'(i), 5'd0, 3'b000, 5'(i + 1), 7'h13}, 32'h200 + 32'(4 * i), 0, 1);
      total++; if ({last_rdy, out_valid, inst_addr_o} !== {2'b11, 32'h200 + 32'(4 * i)}) begin
        bad++; $display("FAIL b2b[%0d] got rdy=%b v=%b addr=%h", i, last_rdy, out_valid, inst_addr_o);
      end
    end
  endtask

  task automatic test_load_use();
    cycle(0, NOP, 32'h0, 0, 1);
    cycle(1, 32'h00012283, 32'h500, 0, 1);
    cycle(1, 32'h00128333, 32'h504, 0, 1);
    total++; if ({last_rdy, out_valid} !== 2'b00) begin bad++; $display("FAIL load_use stall got rdy=%b v=%b exp 0 0", last_rdy, out_valid); end
    total++; if ({last_n_rdy, n_out_valid, n_rd_addr} !== {2'b11, 5'd6}) begin
      bad++; $display("FAIL no_interlock got rdy=%b v=%b rd=%0d exp 1 1 6", last_n_rdy, n_out_valid, n_rd_addr);
    end
    cycle(1, 32'h00128333, 32'h504, 0, 1);
    total++; if ({last_rdy, last_rs1, out_valid, rd_addr_o, op1_o} !== {1'b1, 5'd5, 1'b1, 5'd6, regs[5]}) begin
      bad++; $display("FAIL load_use issue got rdy=%b rs1=%0d v=%b rd=%0d op1=%h", last_rdy, last_rs1, out_valid, rd_addr_o, op1_o);
    end
    cycle(1, 32'h00012003, 32'h508, 0, 1);
    cycle(1, 32'h00100333, 32'h50C, 0, 1);
    total++; if ({last_rdy, out_valid, inst_addr_o} !== {2'b11, 32'h50C}) begin
      bad++; $display("FAIL x0_dep got rdy=%b v=%b addr=%h exp 1 1 50c", last_rdy, out_valid, inst_addr_o);
    end
  endtask

  task automatic test_stall();
    cycle(1, 32'h123451B7, 32'h600, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, 32'h00100393, 32'h604, 0, 0);
      total++; if ({last_rdy, out_valid, op1_o, inst_o} !== {2'b01, 32'h12345000, 32'h123451B7}) begin
        bad++; $display("FAIL stall[%0d] got rdy=%b v=%b op1=%h inst=%h", i, last_rdy, out_valid, op1_o, inst_o);
      end
    end
    cycle(1, 32'h00100393, 32'h604, 0, 1);
    total++; if ({last_rdy, out_valid, inst_o} !== {2'b11, 32'h00100393}) begin
      bad++; $display("FAIL stall release got rdy=%b v=%b inst=%h", last_rdy, out_valid, inst_o);
    end
  endtask

  task automatic test_flush();
    cycle(1, 32'h00500413, 32'h700, 1, 1);
    total++; if ({out_valid, inst_o} !== {1'b0, NOP}) begin bad++; $display("FAIL flush got v=%b inst=%h exp 0 %h", out_valid, inst_o, NOP); end
    cycle(1, 32'h00600493, 32'h704, 0, 1);
    total++; if ({out_valid, inst_addr_o, rd_addr_o} !== {1'b1, 32'h704, 5'd9}) begin
      bad++; $display("FAIL after_flush got v=%b addr=%h rd=%0d", out_valid, inst_addr_o, rd_addr_o);
    end
  endtask

  task automatic test_illegal();
    cycle(1, 32'hFFFFFFFF, 32'h800, 0, 1);
    total++; if ({out_valid, illegal_o, reg_wen} !== 3'b110) begin bad++; $display("FAIL illegal_ones got v=%b ill=%b wen=%b", out_valid, illegal_o, reg_wen); end
    cycle(1, 32'h02208133, 32'h804, 0, 1);
    total++; if ({out_valid, illegal_o, reg_wen, op1_o, op2_o} !== {3'b110, 64'd0}) begin
      bad++; $display("FAIL illegal_f7 got v=%b ill=%b wen=%b op1=%h op2=%h", out_valid, illegal_o, reg_wen, op1_o, op2_o);
    end
    cycle(1, 32'hFFDFF0EF, 32'h900, 0, 1);
    total++; if ({op1_o, op2_o, reg_wen, illegal_o} !== {32'h900, 32'hFFFFFFFC, 2'b10}) begin
      bad++; $display("FAIL jal got op1=%h op2=%h wen=%b ill=%b", op1_o, op2_o, reg_wen, illegal_o);
    end
  endtask

  task automatic test_random();
    logic [31:0] pc;
    pc = 32'h1000;
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 4) != 0), rnd_inst(), pc, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 9) < 7));
      pc = pc + 32'd4;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    regs[0] = '0;
    for (int i = 1; i < 32; i++) regs[i] = $urandom;
    m_valid = 0;
    m_e = bubble();
    test_reset();
    test_addi();
    test_back_to_back();
    test_load_use();
    test_stall();
    test_flush();
    test_illegal();
    test_random();
    test_reset();
    test_addi();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
